// File: rtl/rc4_key_schedule.sv
// RC4 key-scheduling stage.
// Fills a 256-byte single-port S RAM with the identity permutation, then
// shuffles it under a 24-bit key (standard RC4 KSA). Each shuffle step
// takes eight cycles because the RAM has one read/write port and one
// cycle of read latency. The outputs are decoded from the state and the
// internal registers only, so no input reaches an output combinationally.

module rc4_key_schedule #(
   parameter int KEY_LENGTH = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] key,
   input  logic [7:0]  s_q,
   output logic        finish,
   output logic        s_wren,
   output logic [7:0]  s_address,
   output logic [7:0]  s_data
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FILL   = 4'd1,
      RD_I   = 4'd2,
      GET_SI = 4'd3,
      CALC_J = 4'd4,
      RD_J   = 4'd5,
      GET_SJ = 4'd6,
      WR_I   = 4'd7,
      WR_J   = 4'd8,
      NEXT   = 4'd9,
      DONE   = 4'd10
   } state_t;

   state_t      state;
   state_t      state_next;

   // i walks the fill and the shuffle; j is the running shuffle index.
   logic [7:0]  i;
   logic [7:0]  i_next;
   logic [7:0]  j;
   logic [7:0]  j_next;
   // si/sj hold S[i] and S[j] between the reads and the swap writes.
   logic [7:0]  si;
   logic [7:0]  si_next;
   logic [7:0]  sj;
   logic [7:0]  sj_next;
   // Key copy taken at start, so the caller may change key mid-run.
   logic [23:0] key_r;
   logic [23:0] key_next;

   // Byte of the key selected by (idx mod KEY_LENGTH); byte 0 is the MSB.
   function automatic logic [7:0] key_byte(input logic [23:0] k,
                                           input logic [7:0]  idx);
      logic [7:0] sel;
      sel = idx % 8'(KEY_LENGTH);
      case (sel)
         8'd0:    key_byte = k[23:16];
         8'd1:    key_byte = k[15:8];
         default: key_byte = k[7:0];
      endcase
   endfunction

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers; all cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         i     <= 8'd0;
         j     <= 8'd0;
         si    <= 8'd0;
         sj    <= 8'd0;
         key_r <= 24'd0;
      end else begin
         i     <= i_next;
         j     <= j_next;
         si    <= si_next;
         sj    <= sj_next;
         key_r <= key_next;
      end
   end

   // Next-state and next-register logic.
   always_comb begin
      state_next = state;
      i_next     = i;
      j_next     = j;
      si_next    = si;
      sj_next    = sj;
      key_next   = key_r;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = FILL;
               key_next   = key;
               i_next     = 8'd0;
               j_next     = 8'd0;
            end else begin
               state_next = IDLE;
            end
         end

         // One identity write per cycle; i wraps back to 0 after 255,
         // which is exactly where the shuffle wants to begin.
         FILL: begin
            i_next = i + 8'd1;
            if (i == 8'hFF) begin
               state_next = RD_I;
            end else begin
               state_next = FILL;
            end
         end

         RD_I: begin
            state_next = GET_SI;
         end

         // Read data for address i is valid now.
         GET_SI: begin
            si_next    = s_q;
            state_next = CALC_J;
         end

         // 8-bit wrapping sum, carry discarded.
         CALC_J: begin
            j_next     = j + si + key_byte(key_r, i);
            state_next = RD_J;
         end

         RD_J: begin
            state_next = GET_SJ;
         end

         GET_SJ: begin
            sj_next    = s_q;
            state_next = WR_I;
         end

         WR_I: begin
            state_next = WR_J;
         end

         // When i == j both writes target one address with one value.
         WR_J: begin
            state_next = NEXT;
         end

         NEXT: begin
            if (i == 8'hFF) begin
               state_next = DONE;
            end else begin
               i_next     = i + 8'd1;
               state_next = RD_I;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode from state and registers.
   always_comb begin
      finish    = 1'b0;
      s_wren    = 1'b0;
      s_address = 8'd0;
      s_data    = 8'd0;

      case (state)
         IDLE: begin
            s_address = 8'd0;
         end

         FILL: begin
            s_address = i;
            s_data    = i;
            s_wren    = 1'b1;
         end

         RD_I, GET_SI: begin
            s_address = i;
         end

         CALC_J: begin
            s_address = i;
         end

         RD_J, GET_SJ: begin
            s_address = j;
         end

         WR_I: begin
            s_address = i;
            s_data    = sj;
            s_wren    = 1'b1;
         end

         WR_J: begin
            s_address = j;
            s_data    = si;
            s_wren    = 1'b1;
         end

         NEXT: begin
            s_address = i;
         end

         DONE: begin
            finish = 1'b1;
         end

         default: begin
            finish = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rc4_key_schedule.sv
// Self-checking bench for rc4_key_schedule: behavioural S RAM, software
// RC4 KSA reference, per-cycle output expectations and final RAM image.

module tb_rc4_key_schedule;

   localparam int NCYC = 2312;

   logic        clock;
   logic        reset;
   logic        start;
   logic [23:0] key;
   logic [7:0]  s_q;
   logic        finish;
   logic        s_wren;
   logic [7:0]  s_address;
   logic [7:0]  s_data;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] mem  [0:255];
   logic [7:0] snap [0:255];

   // reference model results
   int m_s   [0:255];
   int m_j   [0:255];
   int m_wid [0:255];
   int m_wjd [0:255];

   // per-cycle logs of the last run
   logic       log_en [0:NCYC];
   logic [7:0] log_a  [0:NCYC];
   logic [7:0] log_d  [0:NCYC];
   int         fin_count;
   int         fin_cycle;

   rc4_key_schedule #(.KEY_LENGTH(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .key       (key),
      .s_q       (s_q),
      .finish    (finish),
      .s_wren    (s_wren),
      .s_address (s_address),
      .s_data    (s_data)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // single-port S RAM with one cycle read latency
   always @(posedge clock) begin
      if (s_wren) mem[s_address] <= s_data;
      s_q <= mem[s_address];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Software RC4 KSA on a 256-entry array, recording each swap.
   task automatic build_model(input logic [23:0] k);
      int s [0:255];
      int jj;
      int kb;
      int t;
      for (int n = 0; n < 256; n++) s[n] = n;
      jj = 0;
      for (int n = 0; n < 256; n++) begin
         kb = (int'(k) >> (8 * (2 - (n % 3)))) & 255;
         jj = (jj + s[n] + kb) % 256;
         m_j[n]   = jj;
         m_wid[n] = s[jj];
         m_wjd[n] = s[n];
         t = s[n]; s[n] = s[jj]; s[jj] = t;
      end
      for (int n = 0; n < 256; n++) m_s[n] = s[n];
   endtask

   // One run: start at edge E0, then NCYC cycles sampled on the falling edge.
   task automatic run(input logic [23:0] k0, input int key_cyc, input int busy_a,
                      input int busy_b, input int rst_cyc, input bit hold_start,
                      input bit pre_reset);
      bit         e_en, e_f, c_a, c_d;
      int         e_a, e_d, p, off;
      build_model(k0);
      fin_count = 0;
      fin_cycle = -1;
      @(negedge clock);
      if (pre_reset) begin
         reset = 1'b1;
         @(negedge clock);
         @(negedge clock);
         reset = 1'b0;
      end
      key   = k0;
      start = 1'b1;
      @(posedge clock);
      for (int c = 1; c <= NCYC; c++) begin
         @(negedge clock);
         log_en[c] = s_wren;
         log_a[c]  = s_address;
         log_d[c]  = s_data;
         if (finish === 1'b1) begin
            if (fin_count == 0) begin
               fin_cycle = c;
               for (int n = 0; n < 256; n++) snap[n] = mem[n];
            end
            fin_count++;
         end
         // expected outputs for cycle c
         e_en = 1'b0; e_f = 1'b0; c_a = 1'b1; c_d = 1'b1; e_a = 0; e_d = 0;
         if (rst_cyc != 0 && c > rst_cyc) begin
            e_en = 1'b0;
         end else if (c <= 256) begin
            e_en = 1'b1; e_a = c - 1; e_d = c - 1;
         end else if (c <= 2304) begin
            p = (c - 257) / 8; off = (c - 257) % 8; c_d = 1'b0;
            case (off)
               0, 1: e_a = p;
               3, 4: e_a = m_j[p];
               5: begin e_en = 1'b1; e_a = p; e_d = m_wid[p]; c_d = 1'b1; end
               6: begin e_en = 1'b1; e_a = m_j[p]; e_d = m_wjd[p]; c_d = 1'b1; end
               default: c_a = 1'b0;
            endcase
         end else if (c == 2305) begin
            e_f = 1'b1;
         end else if (hold_start && c >= 2307) begin
            e_en = 1'b1; e_a = c - 2307; e_d = c - 2307;
         end
         chk($sformatf("wren c%0d", c), 32'(s_wren), 32'(e_en));
         chk($sformatf("finish c%0d", c), 32'(finish), 32'(e_f));
         if (c_a) chk($sformatf("addr c%0d", c), 32'(s_address), 32'(e_a));
         if (c_d) chk($sformatf("data c%0d", c), 32'(s_data), 32'(e_d));
         // drive inputs for the next edge
         if (c == key_cyc) key = 24'hFFFFFF;
         start = (c == busy_a) || (c == busy_b) || (hold_start && c >= 2305);
         reset = (rst_cyc != 0 && c == rst_cyc);
      end
      start = 1'b0;
      reset = 1'b0;
   endtask

   task automatic check_done(input string tag);
      chk({tag, " finish count"}, 32'(fin_count), 32'd1);
      chk({tag, " finish cycle"}, 32'(fin_cycle), 32'd2305);
      for (int n = 0; n < 256; n++)
         chk($sformatf("%s ram[%0d]", tag, n), 32'(snap[n]), 32'(m_s[n]));
   endtask

   initial begin
      int distinct;
      bit seen [0:255];
      logic [23:0] rk;

      reset = 1'b1;
      start = 1'b0;
      key   = 24'd0;
      @(posedge clock);
      @(negedge clock);
      chk("reset finish", 32'(finish), 32'd0);
      chk("reset wren", 32'(s_wren), 32'd0);
      chk("reset addr", 32'(s_address), 32'd0);
      chk("reset data", 32'(s_data), 32'd0);

      // zero key: fill and early shuffle steps
      run(24'h000000, 0, 0, 0, 0, 1'b0, 1'b1);
      for (int n = 0; n < 256; n++) seen[n] = 1'b0;
      distinct = 0;
      for (int c = 1; c <= 256; c++) begin
         if (log_en[c] === 1'b1 && !seen[log_a[c]]) begin
            seen[log_a[c]] = 1'b1;
            distinct++;
         end
      end
      chk("fill distinct writes", 32'(distinct), 32'd256);
      chk("fill c1 addr", 32'(log_a[1]), 32'h00);
      chk("fill c256 addr", 32'(log_a[256]), 32'hFF);
      chk("fill c256 data", 32'(log_d[256]), 32'hFF);
      chk("zk i0 wr_i addr", 32'(log_a[262]), 32'h00);
      chk("zk i0 wr_j data", 32'(log_d[263]), 32'h00);
      chk("zk i1 wr_j addr", 32'(log_a[271]), 32'h01);
      chk("zk i1 wr_j data", 32'(log_d[271]), 32'h01);
      chk("zk i2 wr_i addr", 32'(log_a[278]), 32'h02);
      chk("zk i2 wr_i data", 32'(log_d[278]), 32'h03);
      chk("zk i2 wr_j addr", 32'(log_a[279]), 32'h03);
      chk("zk i2 wr_j data", 32'(log_d[279]), 32'h02);
      check_done("zero key");

      // key indexing, with start held across DONE
      run(24'h000249, 0, 0, 0, 0, 1'b1, 1'b1);
      check_done("key 000249");

      // key changed in cycle 100 has no effect
      rk = 24'($urandom());
      run(rk, 100, 0, 0, 0, 1'b0, 1'b1);
      check_done("key stability");

      // start pulses while busy are ignored
      rk = 24'($urandom());
      run(rk, 0, 10, 1000, 0, 1'b0, 1'b1);
      check_done("start busy");

      // reset in cycle 1500 aborts without finish
      rk = 24'($urandom());
      run(rk, 0, 0, 0, 1500, 1'b0, 1'b1);
      chk("reset run finish count", 32'(fin_count), 32'd0);
      chk("post reset c1501 wren", 32'(log_en[1501]), 32'd0);
      chk("post reset c1501 addr", 32'(log_a[1501]), 32'd0);

      // next start after the abort runs to completion
      rk = 24'($urandom());
      run(rk, 0, 0, 0, 0, 1'b0, 1'b0);
      check_done("after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rc4_key_schedule.md
# rc4_key_schedule

RC4 key-scheduling stage: initialises the 256-byte S RAM to the identity permutation, then shuffles it with a 24-bit secret key. It sits directly upstream of the decryption FSM on the same single-port S RAM; the top level passes this block's `finish` to the decrypt FSM's `start` and muxes S RAM control to whichever stage is active. All S RAM writes of the permutation originate here.

## Interface
- `KEY_LENGTH`, default 3: key length in bytes; the key byte index is `i mod KEY_LENGTH`.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; forces `IDLE` and clears all internal registers.
- `start` in 1: sampled in `IDLE` only; a high level begins a run.
- `key` in 24: secret key; byte 0 = `key[23:16]`, byte 1 = `key[15:8]`, byte 2 = `key[7:0]`.
- `s_q` in 8: S RAM read data, valid in the cycle after its address was presented.
- `finish` out 1: one-cycle pulse when the permutation is complete.
- `s_wren` out 1: S RAM write enable.
- `s_address` out 8: S RAM address.
- `s_data` out 8: S RAM write data.

## Operation
- Registers: `i`, `j`, `si`, `sj`, and `key_r` (24 bits, captured when leaving `IDLE` on start). `key` changes during a run have no effect.
- `IDLE`: all outputs 0. On `start`, capture `key_r`, clear `i` and `j`, and go to `FILL`.
- `FILL`: `s_address=i`, `s_data=i`, `s_wren=1`, then `i<=i+1`. Leave for `RD_I` after the cycle with `i==255`; `i` wraps to 0 and `j` stays 0.
- Shuffle loop, one pass per `i` from 0 to 255:
  - `RD_I`: `s_address=i`.
  - `GET_SI`: `s_address=i`, `si<=s_q`.
  - `CALC_J`: `j<=(j+si+keybyte(i mod KEY_LENGTH)) mod 256`.
  - `RD_J`: `s_address=j`.
  - `GET_SJ`: `s_address=j`, `sj<=s_q`.
  - `WR_I`: `s_address=i`, `s_data=sj`, `s_wren=1`.
  - `WR_J`: `s_address=j`, `s_data=si`, `s_wren=1`.
  - `NEXT`: if `i==255` go to `DONE`, else `i<=i+1` and go to `RD_I`.
- `DONE`: `finish=1` for one cycle, then `IDLE`.
- `s_wren=0` in every other state. `s_address` and `s_data` are 0 in `IDLE` and `DONE`.
- Arithmetic is 8-bit unsigned with natural wrap. The sum is computed in 8 bits and truncated, with no carry kept.
- Case `i==j`: both writes land on the same address with the same value, which is legal.
- A `start` level outside `IDLE` is ignored. A `start` held high across `DONE` begins a new run on the cycle `IDLE` is re-entered.
- `reset` in any state takes effect at the next edge: state becomes `IDLE`, outputs are 0 from the following cycle, and `finish` is not pulsed. RAM contents are then partial and undefined.

## Timing
- Reset values: `finish=0`, `s_wren=0`, `s_address=0`, `s_data=0`, state `IDLE`.
- RAM read latency is one cycle. The address is held for two cycles (`RD_x`, `GET_Sx`) and data is captured in the second.
- Take edge E0 as the edge at which `start` is sampled in `IDLE`:
  - `FILL` occupies cycles 1–256.
  - Shuffle occupies cycles 257–2304, 8 cycles per `i`.
  - `finish` is high in cycle 2305.
  - Total latency is 2305 cycles, independent of key.
- Outputs are pure decodes of state and registers, with no combinational path from inputs to outputs.

## Test plan
- Fill check: `key=0x000000`, pulse `start`, and monitor writes during `FILL`. Required: cycle 1 writes address 0x00 with data 0x00; cycle 256 writes address 0xFF with data 0xFF; 256 writes in total, none repeated.
- Zero-key start of shuffle: `key=0x000000`. Required:
  - `i=0` gives `j=0`, so no change.
  - `i=1` gives `j=1`, so no change.
  - `i=2` gives `j=3`, so `WR_I` writes s[2]=0x03 and `WR_J` writes s[3]=0x02.
  - Final RAM matches a software RC4 KSA model for all 256 bytes.
- Key indexing: `key=0x000249`. Required: the final RAM image matches the software model, and `finish` is high in exactly cycle 2305 after the start edge.
- Key stability: change `key` to 0xFFFFFF in cycle 100. Required: the result is identical to a run with the original key.
- Start while busy: pulse `start` again at cycles 10 and 1000. Required: no restart, a single `finish` at cycle 2305, and `IDLE` after it.
- Reset mid-operation: assert `reset` for one cycle at cycle 1500. Required:
  - Next cycle: `s_wren=0`, `s_address=0`, `finish=0`.
  - No `finish` pulse follows.
  - A subsequent `start` yields a correct full run with `finish` 2305 cycles later.
